alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Downstream consumer of the BCD watch counter. It holds a user-settable alarm time in BCD and compares it against the current `hourdec/hourone/mindec/minone` digits. On a match it sequences ring, snooze and stop through a small state machine and produces a gated buzzer square wave. Its alarm-digit outputs can feed the same display multiplexer as the watch digits when the display is in set mode.

## Interface
Parameters:
- `ALM_H_INIT` (default 8'h07): reset alarm hour, BCD, {dec, one}.
- `ALM_M_INIT` (default 8'h00): reset alarm minute, BCD, {dec, one}.
- `SNOOZE_MIN` (default 5): snooze length in minutes, 1..15.
- `RING_CYCLES` (default 1000): cycles of RINGING before automatic timeout, ≥2.
- `BUZZ_DIV` (default 4): buzzer half-period in cycles, ≥1.

Ports:
- `clk`, input, 1: the only clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `hourdec_now`, `hourone_now`, `mindec_now`, `minone_now`, input, 4 each: current time from the watch, BCD.
- `alarm_en`, input, 1: level; 1 = alarm armed.
- `inc_hour`, input, 1: single-cycle pulse, already debounced; adds 1 to the alarm hour.
- `inc_min`, input, 1: single-cycle pulse, already debounced; adds 1 to the alarm minute.
- `snooze`, input, 1: single-cycle pulse.
- `stop`, input, 1: single-cycle pulse.
- `alm_hourdec`, `alm_hourone`, `alm_mindec`, `alm_minone`, output, 4 each: stored alarm time, BCD.
- `ringing`, output, 1: state is RINGING.
- `snoozing`, output, 1: state is SNOOZE.
- `buzzer`, output, 1: square wave while RINGING, 0 otherwise.

## Operation
- **States:** IDLE, ARMED, RINGING, SNOOZE.
- **Reset:** state IDLE. Alarm digits load from `ALM_H_INIT` / `ALM_M_INIT`. `ringing`, `snoozing` and `buzzer` are 0. `match_q`, `match_d` and `ring_cnt` are 0. `snooze_cnt` and `buzz_cnt` are 0. `minone_q` loads `minone_now`.
- **Alarm minute increment:** 00→…→59→00, BCD. `alm_minone` counts 9→0 with a carry into `alm_mindec`; `alm_mindec` counts 5→0 with no carry into hours.
- **Alarm hour increment:** 00→…→23→00. `alm_hourone` counts 9→0 with a carry into `alm_hourdec`; 23 wraps to 00.
- **Simultaneous increments:** `inc_hour` and `inc_min` in the same cycle apply both. Increments are accepted in every state and never change the state.
- **Compare:** `match_q <= (all four now digits == all four alarm digits)` and `match_d <= match_q`. A trigger is `match_q & ~match_d`. Triggering only on the first matching cycle means a stopped alarm does not re-fire within the same minute.
- **Minute tick:** `minone_q <= minone_now`. A tick is `minone_now != minone_q`.
- **Transitions, evaluated in this priority order:**
  1. `alarm_en` = 0: any state → IDLE.
  2. IDLE with `alarm_en` = 1 → ARMED.
  3. ARMED on a trigger → RINGING, with `ring_cnt` cleared.
  4. RINGING on `stop` → ARMED. Otherwise, RINGING on `snooze` → SNOOZE, with `snooze_cnt` = `SNOOZE_MIN`. Otherwise, RINGING with `ring_cnt` == `RING_CYCLES`-1 → ARMED (timeout). Otherwise `ring_cnt` +1.
  5. SNOOZE on `stop` → ARMED. Otherwise, on a minute tick, `snooze_cnt` −1; when the tick arrives with `snooze_cnt` == 1 → RINGING, with `ring_cnt` cleared.
- **Buzzer:** in RINGING, `buzz_cnt` counts 0..`BUZZ_DIV`-1 and `buzzer` toggles on each wrap. On entry to RINGING, `buzz_cnt` = 0 and `buzzer` = 0. Outside RINGING, `buzzer` is forced to 0.
- **Ignored pulses:** `snooze` or `stop` outside the states listed above has no effect.

## Timing
- **Trigger latency:** the now digits become equal to the alarm digits before edge k, so `match_q` = 1 after edge k and `ringing` = 1 after edge k+1.
- **`alarm_en` falling:** IDLE and `ringing` = `buzzer` = 0 after the next edge.
- **`stop` / `snooze`:** take effect on the edge that samples the pulse. Outputs change the same edge.
- **First buzzer toggle:** `BUZZ_DIV` cycles after entering RINGING.
- **Timeout:** RINGING lasts exactly `RING_CYCLES` cycles.
- **Snooze expiry:** RINGING after the edge that samples the `SNOOZE_MIN`-th minute tick.
- **Outputs:** all outputs are registered; no combinational input-to-output paths.
- **Reset mid-ring:** reset dominates all inputs and returns the block to IDLE in one cycle.

## Test plan
- **Increment wrap:** reset with defaults, then pulse `inc_min` 60 times → `alm_mindec`/`alm_minone` = 0/0 and hour still 07. Pulse `inc_hour` 17 times → hour 00.
- **Trigger and timeout:** `alarm_en` = 1, `RING_CYCLES` = 10, now digits step 06:59 → 07:00 → `ringing` rises 2 cycles later. `buzzer` toggles every 4 cycles. `ringing` falls after 10 cycles and does not re-fire while now stays 07:00.
- **Stop:** while ringing, pulse `stop` → ARMED and `buzzer` = 0 on the next edge. Hold now at 07:00 → no re-trigger. Step to 07:01 and back to 07:00 → rings again.
- **Snooze:** pulse `snooze` during RINGING → `snoozing` = 1. Apply 4 minute ticks → still snoozing. Apply the 5th tick → `ringing` = 1.
- **Disable and simultaneous pulses:** drop `alarm_en` during SNOOZE → IDLE next cycle, and a matching time causes no ring. `snooze` and `stop` in the same cycle while RINGING → ARMED.
- **Reset mid-ring:** assert `rst` during RINGING → IDLE, all flags 0, alarm digits back to 07:00 after one edge.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm time store, BCD compare against the watch and ring/snooze/stop sequencing.
// state   | meaning
// IDLE    | alarm disabled
// ARMED   | waiting for the first cycle of a time match
// RINGING | buzzer active, ring timeout running
// SNOOZE  | counting minute ticks before ringing again
module alarm_ctrl #(
  parameter logic [7:0] ALM_H_INIT  = 8'h07,
  parameter logic [7:0] ALM_M_INIT  = 8'h00,
  parameter int         SNOOZE_MIN  = 5,
  parameter int         RING_CYCLES = 1000,
  parameter int         BUZZ_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic       alarm_en,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       snooze,
  input  logic       stop,
  output logic [3:0] alm_hourdec,
  output logic [3:0] alm_hourone,
  output logic [3:0] alm_mindec,
  output logic [3:0] alm_minone,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);
  localparam int RW = $clog2(RING_CYCLES + 1);
  localparam int BW = $clog2(BUZZ_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RINGING, S_SNOOZE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    ahd_q, ahd_d, aho_q, aho_d, amd_q, amd_d, amo_q, amo_d;
  logic          match_q, match_d, match_prev_q;
  logic [3:0]    minone_q;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [3:0]    snooze_cnt_q, snooze_cnt_d;
  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic          buzzer_q, buzzer_d;
  logic          trigger, min_tick;

  always_comb begin
    ahd_d = ahd_q;
    aho_d = aho_q;
    amd_d = amd_q;
    amo_d = amo_q;
    if (inc_min) begin
      if (amo_q == 4'd9) begin
        amo_d = 4'd0;
        amd_d = (amd_q == 4'd5) ? 4'd0 : amd_q + 4'd1;
      end else begin
        amo_d = amo_q + 4'd1;
      end
    end
    if (inc_hour) begin
      if (ahd_q == 4'd2 && aho_q == 4'd3) begin
        ahd_d = 4'd0;
        aho_d = 4'd0;
      end else if (aho_q == 4'd9) begin
        aho_d = 4'd0;
        ahd_d = ahd_q + 4'd1;
      end else begin
        aho_d = aho_q + 4'd1;
      end
    end
  end

  always_comb begin
    match_d = (hourdec_now == ahd_q) && (hourone_now == aho_q) &&
              (mindec_now == amd_q) && (minone_now == amo_q);
    // Edge-detected so a stopped alarm stays quiet for the rest of the minute
    trigger  = match_q & ~match_prev_q;
    min_tick = (minone_now != minone_q);
  end

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!alarm_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (trigger) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
          end
        end
        S_RINGING: begin
          if (stop) begin
            state_d = S_ARMED;
          end else if (snooze) begin
            state_d      = S_SNOOZE;
            snooze_cnt_d = 4'(SNOOZE_MIN);
          end else if (ring_cnt_q == RW'(RING_CYCLES - 1)) begin
            state_d = S_ARMED;
          end else begin
            ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
        S_SNOOZE: begin
          if (stop) begin
            state_d = S_ARMED;
          end else if (min_tick) begin
            snooze_cnt_d = snooze_cnt_q - 4'd1;
            if (snooze_cnt_q == 4'd1) begin
              state_d    = S_RINGING;
              ring_cnt_d = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Buzzer restarts low on every entry to RINGING and is held low elsewhere
  always_comb begin
    buzz_cnt_d = '0;
    buzzer_d   = 1'b0;
    if (state_d == S_RINGING && state_q == S_RINGING) begin
      if (buzz_cnt_q == BW'(BUZZ_DIV - 1)) begin
        buzzer_d = ~buzzer_q;
      end else begin
        buzz_cnt_d = buzz_cnt_q + BW'(1);
        buzzer_d   = buzzer_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ahd_q        <= ALM_H_INIT[7:4];
      aho_q        <= ALM_H_INIT[3:0];
      amd_q        <= ALM_M_INIT[7:4];
      amo_q        <= ALM_M_INIT[3:0];
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
      minone_q     <= minone_now;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      buzz_cnt_q   <= '0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ahd_q        <= ahd_d;
      aho_q        <= aho_d;
      amd_q        <= amd_d;
      amo_q        <= amo_d;
      match_q      <= match_d;
      match_prev_q <= match_q;
      minone_q     <= minone_now;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      buzz_cnt_q   <= buzz_cnt_d;
      buzzer_q     <= buzzer_d;
    end
  end

  assign alm_hourdec = ahd_q;
  assign alm_hourone = aho_q;
  assign alm_mindec  = amd_q;
  assign alm_minone  = amo_q;
  assign ringing     = (state_q == S_RINGING);
  assign snoozing    = (state_q == S_SNOOZE);
  assign buzzer      = buzzer_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl with a 10-cycle ring timeout.
module tb_alarm_ctrl;
  logic       clk = 1'b0;
  logic       rst, alarm_en, inc_hour, inc_min, snooze, stop;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic [3:0] alm_hourdec, alm_hourone, alm_mindec, alm_minone;
  logic       ringing, snoozing, buzzer;

  alarm_ctrl #(.RING_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .alarm_en(alarm_en), .inc_hour(inc_hour), .inc_min(inc_min),
    .snooze(snooze), .stop(stop),
    .alm_hourdec(alm_hourdec), .alm_hourone(alm_hourone),
    .alm_mindec(alm_mindec), .alm_minone(alm_minone),
    .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_alm;
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   mh, mm;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] flags();
    return {13'd0, ringing, snoozing, buzzer};
  endfunction

  function automatic logic [15:0] alm();
    return {alm_hourdec, alm_hourone, alm_mindec, alm_minone};
  endfunction

  function automatic logic [15:0] bcd(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  // ringing=1, buzzer toggles every 4 cycles, timeout after 10 cycles
  function automatic logic [15:0] ring_flags(input int j);
    if (j >= 10) return 16'd0;
    return {13'd0, 1'b1, 1'b0, 1'((j / 4) % 2)};
  endfunction

  task automatic push(input bit is_alm, input string tag, input logic [15:0] v);
    exp_t e;
    e.is_alm = is_alm;
    e.tag    = tag;
    e.val    = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.is_alm ? alm() : flags(), e.val);
    end
  endtask

  task automatic set_now(input int h, input int m);
    {hourdec_now, hourone_now, mindec_now, minone_now} = bcd(h, m);
  endtask

  task automatic do_inc(input bit ih, input bit im, input string tag);
    inc_hour = ih;
    inc_min  = im;
    if (ih) mh = (mh + 1) % 24;
    if (im) mm = (mm + 1) % 60;
    push(1'b1, tag, bcd(mh, mm));
    cyc();
    inc_hour = 1'b0;
    inc_min  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alarm_en = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
    snooze = 1'b0; stop = 1'b0;
    set_now(6, 59);
    mh = 7; mm = 0;
    push(1'b0, "rst_flags", 16'd0);
    push(1'b1, "rst_alm", 16'h0700);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 60; i++) do_inc(1'b0, 1'b1, "inc_min_wrap");
    for (int i = 0; i < 17; i++) do_inc(1'b1, 1'b0, "inc_hour_wrap");
    for (int i = 0; i < 7; i++)  do_inc(1'b1, 1'b0, "inc_hour");
    do_inc(1'b1, 1'b1, "inc_both");
    for (int i = 0; i < 59; i++) do_inc(1'b0, 1'b1, "inc_min");
    for (int i = 0; i < 23; i++) do_inc(1'b1, 1'b0, "inc_hour_back");
    push(1'b1, "alm_0700", 16'h0700);
    push(1'b0, "idle_flags", 16'd0);
    cyc();

    alarm_en = 1'b1;
    push(1'b0, "armed", 16'd0);
    cyc(); cyc(); cyc();
    set_now(7, 0);
    push(1'b0, "match_edge", 16'd0);
    cyc();
    push(1'b0, "ring_rise", 16'h4);
    cyc();
    for (int j = 1; j <= 10; j++) begin push(1'b0, "ring_timeout", ring_flags(j)); cyc(); end
    for (int i = 0; i < 5; i++) begin push(1'b0, "no_refire", 16'd0); cyc(); end

    set_now(7, 1); cyc(); cyc();
    set_now(7, 0);
    push(1'b0, "rearm_match", 16'd0); cyc();
    push(1'b0, "ring2", 16'h4); cyc();
    for (int j = 1; j <= 5; j++) begin push(1'b0, "ring2_buzz", ring_flags(j)); cyc(); end
    stop = 1'b1;
    push(1'b0, "stop", 16'd0); cyc();
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin push(1'b0, "stop_hold", 16'd0); cyc(); end
    set_now(7, 1); cyc(); cyc();
    set_now(7, 0);
    push(1'b0, "rearm2_match", 16'd0); cyc();
    push(1'b0, "ring3", 16'h4); cyc();

    snooze = 1'b1;
    push(1'b0, "snooze", 16'h2); cyc();
    snooze = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_now(7, k);
      push(1'b0, "snz_tick", 16'h2); cyc();
      push(1'b0, "snz_notick", 16'h2); cyc();
    end
    set_now(7, 5);
    push(1'b0, "snz_expire", 16'h4); cyc();
    for (int j = 1; j <= 10; j++) begin push(1'b0, "ring_after_snz", ring_flags(j)); cyc(); end

    set_now(7, 0); cyc();
    push(1'b0, "ring4", 16'h4); cyc();
    snooze = 1'b1; stop = 1'b1;
    push(1'b0, "snooze_and_stop", 16'd0); cyc();
    snooze = 1'b0; stop = 1'b0;

    set_now(7, 1); cyc();
    set_now(7, 0);
    push(1'b0, "rearm3_match", 16'd0); cyc();
    push(1'b0, "ring5", 16'h4); cyc();
    snooze = 1'b1;
    push(1'b0, "snooze2", 16'h2); cyc();
    snooze = 1'b0;
    alarm_en = 1'b0;
    push(1'b0, "disable", 16'd0); cyc();
    set_now(7, 1); cyc();
    set_now(7, 0);
    for (int i = 0; i < 4; i++) begin push(1'b0, "disabled_no_ring", 16'd0); cyc(); end

    alarm_en = 1'b1;
    set_now(7, 1); cyc();
    set_now(7, 0);
    push(1'b0, "rearm4_match", 16'd0); cyc();
    push(1'b0, "ring6", 16'h4); cyc();
    inc_min = 1'b1;
    mm = 1;
    push(1'b1, "alm_inc_in_ring", 16'h0701);
    push(1'b0, "inc_keeps_ring", ring_flags(1));
    cyc();
    inc_min = 1'b0;
    for (int j = 2; j <= 4; j++) begin push(1'b0, "ring6_buzz", ring_flags(j)); cyc(); end
    rst = 1'b1;
    mm = 0;
    push(1'b0, "rst_mid_ring", 16'd0);
    push(1'b1, "rst_mid_ring_alm", 16'h0700);
    cyc();
    rst = 1'b0;
    alarm_en = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
